// File: rtl/risc_pkg.sv
// Shared RISC definitions: word width, opcode encoding, fetch FSM states,
// and the opcode legality helper used by the optional illegal-instruction trap.
package risc_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        ADI = 4'd1,
        NDU = 4'd2,
        LHI = 4'd3,
        LW  = 4'd4,
        SW  = 4'd5,
        LM  = 4'd6,
        SM  = 4'd7,
        JAL = 4'd8,
        JLR = 4'd9,
        BEQ = 4'd12
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    function automatic logic is_legal_opcode(input logic [3:0] op);
        case (op)
            ADD, ADI, NDU, LHI, LW, SW, LM, SM, JAL, JLR, BEQ: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, IR latch, memory handshake with ack timeout.
// Optional illegal-opcode flag is built when IFETCH_ILLEGAL_TRAP_EN is defined.
module instr_fetch
    import risc_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [WORD_W-1:0] pc_load_val,
    output logic              mem_rd_en,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] ir,
    output logic              ir_valid,
    output logic [WORD_W-1:0] pc,
    output logic              busy,
    output logic              mem_err
`ifdef IFETCH_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [7:0]        wait_q, wait_d;
    logic              pend_vld_q, pend_vld_d;
    logic [WORD_W-1:0] pend_val_q, pend_val_d;
    logic              err_q, err_d;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic              ill_q, ill_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        wait_d     = wait_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        err_d      = err_q;
`ifdef IFETCH_ILLEGAL_TRAP_EN
        ill_d      = ill_q;
`endif
        mem_rd_en  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            S_IDLE, S_VALID: begin
                // A load accepted with fetch_req lands in pc before the FETCH cycle drives mem_addr.
                if (pc_load) pc_d = pc_load_val;
                if (fetch_req) begin
                    state_d    = S_FETCH;
                    wait_d     = '0;
                    pend_vld_d = 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                    ill_d      = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                if (mem_ack) begin
                    state_d    = S_VALID;
                    ir_d       = mem_rdata;
                    wait_d     = '0;
                    pend_vld_d = 1'b0;
                    if (pc_load)         pc_d = pc_load_val;
                    else if (pend_vld_q) pc_d = pend_val_q;
                    else                 pc_d = pc_q + 16'd1;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                    ill_d      = !is_legal_opcode(mem_rdata[15:12]);
`endif
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    wait_d     = '0;
                    pend_vld_d = 1'b0;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (pc_load) begin
                        pend_vld_d = 1'b1;
                        pend_val_d = pc_load_val;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            wait_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            err_q      <= 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
            ill_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            wait_q     <= wait_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            err_q      <= err_d;
`ifdef IFETCH_ILLEGAL_TRAP_EN
            ill_q      <= ill_d;
`endif
        end
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = (state_q == S_VALID);
    assign mem_err  = err_q;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    assign illegal  = ill_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch (TIMEOUT=3); checks illegal when IFETCH_ILLEGAL_TRAP_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        busy;
    logic        mem_err;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    instr_fetch #(.RESET_PC(16'h0000), .TIMEOUT(3)) dut (
        .clk        (clk),
        .reset      (rst),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .busy       (busy),
        .mem_err    (mem_err)
`ifdef IFETCH_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_pc = 16'h0000;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_illegal(input logic [15:0] w);
        logic [3:0] op;
        op = w[15:12];
        return (op == 4'd10) || (op == 4'd11) || (op >= 4'd13);
    endfunction

    task automatic start_fetch(input logic with_load, input logic [15:0] lv);
        fetch_req   = 1'b1;
        pc_load     = with_load;
        pc_load_val = lv;
        step();
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        if (with_load) exp_pc = lv;
        check_eq("fetch_rd_en", 16'(mem_rd_en), 16'd1);
        check_eq("fetch_busy", 16'(busy), 16'd1);
        check_eq("fetch_addr", mem_addr, exp_pc);
        check_eq("fetch_valid_clr", 16'(ir_valid), 16'd0);
    endtask

    task automatic finish_fetch(input logic [15:0] data, input logic [15:0] next_pc);
        exp_t e;
        int   n;
        e.ir  = data;
        e.pc  = next_pc;
        e.ill = exp_illegal(data);
        sb.push_back(e);
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack = 1'b0;
        exp_pc  = next_pc;
        n = 0;
        while (!ir_valid && n < 8) begin
            step();
            n++;
        end
        if (!ir_valid) begin
            check_eq("ack_wait_expired", 16'(ir_valid), 16'd1);
        end else if (sb.size() == 0) begin
            check_eq("sb_empty", 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            check_eq("ack_latency", 16'(n), 16'd0);
            check_eq("ir", ir, e.ir);
            check_eq("pc", pc, e.pc);
            check_eq("idle_rd_en", 16'(mem_rd_en), 16'd0);
            check_eq("idle_busy", 16'(busy), 16'd0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
            check_eq("illegal", 16'(illegal), 16'(e.ill));
`endif
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pc"}, pc, 16'h0000);
        check_eq({tag, "_ir"}, ir, 16'h0000);
        check_eq({tag, "_valid"}, 16'(ir_valid), 16'd0);
        check_eq({tag, "_rd_en"}, 16'(mem_rd_en), 16'd0);
        check_eq({tag, "_busy"}, 16'(busy), 16'd0);
        check_eq({tag, "_err"}, 16'(mem_err), 16'd0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
        check_eq({tag, "_illegal"}, 16'(illegal), 16'd0);
`endif
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        check_reset_vals("rst");
        rst = 1'b0;
        step();
        step();
        step();
        check_eq("post_rst_quiet", 16'(mem_rd_en), 16'd0);

        // Basic zero-wait fetch
        start_fetch(1'b0, 16'h0);
        finish_fetch(16'h1234, 16'h0001);

        // Wait states, ignored fetch_req in FETCH, ignored ack outside FETCH
        start_fetch(1'b0, 16'h0);
        check_eq("ir_hold", ir, 16'h1234);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check_eq("wait_busy", 16'(busy), 16'd1);
        check_eq("wait_err", 16'(mem_err), 16'd0);
        finish_fetch(16'h5678, 16'h0002);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        check_eq("stray_ack_ir", ir, 16'h5678);
        check_eq("stray_ack_pc", pc, 16'h0002);
        check_eq("stray_ack_valid", 16'(ir_valid), 16'd1);

        // pc_load in VALID, then wrap at 16'hFFFF
        pc_load     = 1'b1;
        pc_load_val = 16'hFFFF;
        step();
        pc_load = 1'b0;
        exp_pc  = 16'hFFFF;
        check_eq("load_valid_pc", pc, 16'hFFFF);
        check_eq("load_valid_busy", 16'(busy), 16'd0);
        start_fetch(1'b0, 16'h0);
        finish_fetch(16'h1111, 16'h0000);

        // Pending load in FETCH, later load overwrites
        start_fetch(1'b0, 16'h0);
        pc_load     = 1'b1;
        pc_load_val = 16'h0100;
        step();
        pc_load_val = 16'h0040;
        step();
        pc_load = 1'b0;
        check_eq("pend_addr_hold", mem_addr, 16'h0000);
        finish_fetch(16'h2222, 16'h0040);

        // pc_load together with fetch_req
        start_fetch(1'b1, 16'h0200);
        finish_fetch(16'h3333, 16'h0201);

        // Opcode legality
        start_fetch(1'b0, 16'h0);
        finish_fetch(16'hA000, 16'h0202);
        start_fetch(1'b0, 16'h0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
        check_eq("illegal_clr", 16'(illegal), 16'd0);
`endif
        finish_fetch(16'h0000, 16'h0203);
        start_fetch(1'b0, 16'h0);
        finish_fetch(16'hC00F, 16'h0204);
        start_fetch(1'b0, 16'h0);
        finish_fetch(16'hF123, 16'h0205);

        // Timeout after 3 FETCH cycles; pending load discarded
        start_fetch(1'b0, 16'h0);
        pc_load     = 1'b1;
        pc_load_val = 16'h0777;
        step();
        pc_load = 1'b0;
        step();
        check_eq("to_before_busy", 16'(busy), 16'd1);
        check_eq("to_before_err", 16'(mem_err), 16'd0);
        step();
        check_eq("to_err", 16'(mem_err), 16'd1);
        check_eq("to_busy", 16'(busy), 16'd0);
        check_eq("to_rd_en", 16'(mem_rd_en), 16'd0);
        check_eq("to_valid", 16'(ir_valid), 16'd0);
        check_eq("to_pc", pc, 16'h0205);
        start_fetch(1'b0, 16'h0);
        finish_fetch(16'h4444, 16'h0206);
        check_eq("err_sticky", 16'(mem_err), 16'd1);

        // Reset mid-FETCH takes effect without a clock edge
        start_fetch(1'b0, 16'h0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        step();
        rst    = 1'b0;
        exp_pc = 16'h0000;
        step();
        check_eq("midrst_quiet", 16'(mem_rd_en), 16'd0);
        check_eq("sb_drained", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, 15: maximum cycles waited for mem_ack before error; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  input  1  controller request for the next instruction; one-cycle pulse.
REQ-006 pc_load  input  1  load PC from pc_load_val (branch/jump target).
REQ-007 pc_load_val  input  16  new PC value.
REQ-008 mem_rd_en  output  1  instruction-memory read strobe.
REQ-009 mem_addr  output  16  instruction-memory address.
REQ-010 mem_rdata  input  16  instruction-memory read data; valid with mem_ack.
REQ-011 mem_ack  input  1  read-complete strobe.
REQ-012 ir  output  16  latched instruction word, consumed by the controller as IR.
REQ-013 ir_valid  output  1  ir holds a fresh instruction.
REQ-014 pc  output  16  current PC.
REQ-015 busy  output  1  fetch in progress.
REQ-016 mem_err  output  1  sticky timeout flag.
REQ-017 illegal  output  1  present only when IFETCH_ILLEGAL_TRAP_EN is defined.

Function
REQ-018 FSM states are IDLE, FETCH and VALID.
- IDLE->FETCH on fetch_req.
- FETCH->VALID on mem_ack.
- FETCH->IDLE on timeout.
- VALID->FETCH on fetch_req.
REQ-019 In FETCH, mem_rd_en=1, mem_addr=pc and busy=1; in all other states mem_rd_en=0 and busy=0.
REQ-020 On mem_ack in FETCH:
- ir<=mem_rdata.
- pc<=pc+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- ir_valid=1 from the next cycle.
REQ-021 Latency: fetch_req to first mem_rd_en is 1 cycle; mem_ack to ir_valid is 1 cycle; with zero-wait memory, fetch_req to ir_valid is 2 cycles.
REQ-022 ir_valid clears in the cycle after a fetch_req is accepted; ir keeps its old value until the next mem_ack.
REQ-023 pc_load in IDLE or VALID: pc<=pc_load_val next cycle.
REQ-024 pc_load and fetch_req in the same cycle: the fetch uses pc_load_val as the address.
REQ-025 pc_load in FETCH is held in a pending register:
- On mem_ack, pc<=pending value and +1 is not applied.
- A later pc_load in the same FETCH overwrites the pending value.
REQ-026 fetch_req in FETCH is ignored.
REQ-027 mem_ack outside FETCH is ignored.
REQ-028 Timeout:
- A wait counter starts at 0 on entry to FETCH and increments each FETCH cycle without mem_ack.
- When the counter reaches TIMEOUT: mem_err<=1, return to IDLE, pc unchanged, pending load discarded.
REQ-029 mem_err clears only on reset.

Reset
REQ-030 On reset assertion, regardless of state or in-flight fetch:
- state=IDLE, pc=RESET_PC, ir=16'h0000.
- ir_valid=0, mem_rd_en=0, busy=0.
- mem_err=0, illegal=0, wait counter=0, pending load cleared.
REQ-031 After reset deasserts, nothing happens until the first fetch_req.

Configuration
REQ-032 Macro IFETCH_ILLEGAL_TRAP_EN.
- Defined: port illegal exists. It is set with ir_valid when mem_rdata[15:12] is 10, 11, 13, 14 or 15, and clears with ir_valid.
- Undefined: port and logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package risc_pkg holds:
- WORD_W=16.
- The opcode enumeration (ADD=0, ADI=1, NDU=2, LHI=3, LW=4, SW=5, LM=6, SM=7, JAL=8, JLR=9, BEQ=12).
- The fetch-state typedef.
- Function is_legal_opcode().
REQ-034 No sub-module; the wait counter and the pending-load register are inline.

Verification
REQ-035 Bench shall cover:
- Reset, then fetch_req with mem_ack one cycle later and mem_rdata=16'h1234 -> ir=16'h1234, ir_valid=1, pc=1.
- pc=16'hFFFF, then a fetch -> pc wraps to 16'h0000.
- pc_load with pc_load_val=16'h0040 asserted in FETCH, then mem_ack -> pc=16'h0040, not pc+1.
- TIMEOUT=3 and no mem_ack -> mem_err=1 after 3 FETCH cycles, state IDLE, pc unchanged.
- reset asserted mid-FETCH -> outputs immediately at reset values, mem_rd_en=0.
- With IFETCH_ILLEGAL_TRAP_EN defined, mem_rdata=16'hA000 -> illegal=1 together with ir_valid; with 16'h0000 -> illegal=0.
